d_cache_ctrl: RTL

D_CACHE_CTRL -- requirements
Module: d_cache_ctrl

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/d_cache_perf_cnt.sv | 43 ++++
 rtl/d_cache_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Geometry constants and state encoding shared by the direct-mapped data cache controller.
package dcache_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 55;
    localparam int IDX_W  = 6;
    localparam int OFF_W  = 3;
    localparam int LINES  = 64;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT
    } dcache_state_t;

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/d_cache_perf_cnt.sv
// Saturating hit/miss event counters for the data cache controller.
module d_cache_perf_cnt
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_i,
    input  logic             miss_i,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    logic [1:0] inc;

    assign inc = {miss_i, hit_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // Hold at all-ones rather than wrapping back to zero.
            always_comb begin
                cnt_next = cnt_reg;
                if (inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end
        end
    endgenerate

    assign hit_cnt  = g_cnt[0].cnt_reg;
    assign miss_cnt = g_cnt[1].cnt_reg;

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, read-only data cache controller with invalidate-all flush.
// Define DCACHE_PERF_CNT_EN to build the hit/miss performance counters.
module d_cache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic [IDX_W-1:0]  tag_addr_o,
    output logic [TAG_W:0]    tag_wdata_o,
    output logic              tag_wena_o,
    input  logic [TAG_W-1:0]  tag_data_i,
    input  logic              tag_valid_i,
    output logic [IDX_W-1:0]  data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    output logic              data_wena_o,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  perf_hit_cnt,
    output logic [CNT_W-1:0]  perf_miss_cnt
);

    dcache_state_t    state_reg, state_next;
    logic [TAG_W-1:0] req_tag_reg, req_tag_next;
    logic [IDX_W-1:0] req_idx_reg, req_idx_next;
    logic [IDX_W-1:0] flush_idx_reg, flush_idx_next;
    logic             flush_pend_reg, flush_pend_next;
    logic             hit;
    logic             lookup_hit;
    logic             lookup_miss;
    logic             addr_unused;

    // Byte offset within the 8-byte word never affects the lookup.
    assign addr_unused = ^cpu_req_addr[OFF_W-1:0];

    assign hit = tag_valid_i && (tag_data_i == req_tag_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FLUSH;
            req_tag_reg    <= '0;
            req_idx_reg    <= '0;
            flush_idx_reg  <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_tag_reg    <= req_tag_next;
            req_idx_reg    <= req_idx_next;
            flush_idx_reg  <= flush_idx_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        req_tag_next    = req_tag_reg;
        req_idx_next    = req_idx_reg;
        flush_idx_next  = flush_idx_reg;
        flush_pend_next = flush_pend_reg;
        cpu_req_ready   = 1'b0;
        cpu_resp_valid  = 1'b0;
        cpu_resp_data   = '0;
        tag_addr_o      = '0;
        tag_wdata_o     = '0;
        tag_wena_o      = 1'b0;
        data_addr_o     = '0;
        data_wdata_o    = '0;
        data_wena_o     = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        lookup_hit      = 1'b0;
        lookup_miss     = 1'b0;

        // Outputs are forced quiet while reset is held; state reloads on the edge.
        if (!rst) begin
            if (flush_i && (state_reg != IDLE)) begin
                flush_pend_next = 1'b1;
            end

            case (state_reg)
                FLUSH: begin
                    tag_addr_o     = flush_idx_reg;
                    tag_wena_o     = 1'b1;
                    flush_idx_next = flush_idx_reg + 1'b1;
                    if (flush_idx_reg == IDX_W'(LINES - 1)) begin
                        state_next = IDLE;
                    end
                end

                IDLE: begin
                    tag_addr_o  = addr_index(cpu_req_addr);
                    data_addr_o = addr_index(cpu_req_addr);
                    if (flush_i || flush_pend_reg) begin
                        state_next      = FLUSH;
                        flush_pend_next = 1'b0;
                        flush_idx_next  = '0;
                    end else begin
                        cpu_req_ready = 1'b1;
                        if (cpu_req_valid) begin
                            req_tag_next = addr_tag(cpu_req_addr);
                            req_idx_next = addr_index(cpu_req_addr);
                            state_next   = LOOKUP;
                        end
                    end
                end

                LOOKUP: begin
                    tag_addr_o  = req_idx_reg;
                    data_addr_o = req_idx_reg;
                    if (hit) begin
                        cpu_resp_valid = 1'b1;
                        cpu_resp_data  = data_rdata_i;
                        lookup_hit     = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        lookup_miss = 1'b1;
                        state_next  = MISS_REQ;
                    end
                end

                MISS_REQ: begin
                    tag_addr_o    = req_idx_reg;
                    data_addr_o   = req_idx_reg;
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {req_tag_reg, req_idx_reg, {OFF_W{1'b0}}};
                    if (mem_req_ready) begin
                        state_next = MISS_WAIT;
                    end
                end

                MISS_WAIT: begin
                    tag_addr_o  = req_idx_reg;
                    data_addr_o = req_idx_reg;
                    // The refill beat is written and forwarded to the CPU in the same cycle.
                    if (mem_resp_valid) begin
                        tag_wena_o     = 1'b1;
                        tag_wdata_o    = {1'b1, req_tag_reg};
                        data_wena_o    = 1'b1;
                        data_wdata_o   = mem_resp_data;
                        cpu_resp_valid = 1'b1;
                        cpu_resp_data  = mem_resp_data;
                        state_next     = IDLE;
                    end
                end

                default: begin
                    state_next = FLUSH;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    d_cache_perf_cnt u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .hit_i    (lookup_hit),
        .miss_i   (lookup_miss),
        .hit_cnt  (perf_hit_cnt),
        .miss_cnt (perf_miss_cnt)
    );
`else
    logic perf_unused;

    assign perf_unused   = lookup_hit ^ lookup_miss;
    assign perf_hit_cnt  = '0;
    assign perf_miss_cnt = '0;
`endif

endmodule
